max_pool_stream: RTL and testbench
==================================

Name: max_pool_stream

Overview:
- Downstream of the feature-map memory stage. Consumes its serial single-word stream: one feature map at a time, raster order, NumberOfK maps per input image.
- Performs 2x2 stride-2 signed max pooling on that stream and emits a serial stream of pooled values.
- Tags each pooled value with its kernel index and flags end-of-map and end-of-image, so the next layer (dense/nerve layer) can consume the stream directly.

Parameters:
- BitSize, 32, width of each signed two's-complement feature value.
- ImageWidth, 4, side length of each square input feature map; must be even and at least 2.
- NumberOfK, 4, number of feature maps (kernels) per input image.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- res_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data carries a valid pixel this cycle.
- in_data  in  BitSize  signed pixel, raster order (row 0 col 0 first).
- in_image_done  in  1  high together with in_valid on the last pixel of each feature map.
- out_valid  out  1  out_data carries a valid pooled value.
- out_data  out  BitSize  signed pooled value.
- out_kernel_idx  out  max(1,$clog2(NumberOfK))  index of the map that out_data belongs to.
- out_map_done  out  1  high with the last pooled value of each map.
- out_all_done  out  1  high with the last pooled value of map NumberOfK-1.
- sync_err  out  1  sticky; in_image_done arrived on the wrong pixel.

Behaviour:
- Reset (async, res_n=0): all outputs 0; column, row and kernel counters 0; horizontal-pair register and line buffer cleared; sync_err cleared.
- Input flow: no backpressure. Only cycles with in_valid=1 advance state; idle cycles hold all state. in_data and in_image_done are ignored when in_valid=0.
- Counters: col runs 0..ImageWidth-1 and wraps, incrementing row; row runs 0..ImageWidth-1 and wraps, incrementing kernel; kernel runs 0..NumberOfK-1 and wraps to 0.
- Even col: register the pixel as pair_reg.
- Odd col: hmax = signed max(pair_reg, pixel).
  - Even row: store hmax in line_buf[col/2]; the buffer has ImageWidth/2 entries.
  - Odd row: result = signed max(line_buf[col/2], hmax).
- Output timing: on the next rising edge after an odd-row, odd-col beat, drive out_valid=1, out_data=result, out_kernel_idx=current kernel. out_valid is a single-cycle pulse. Latency is exactly 1 clock from the beat that completes the window.
- Outputs per map: (ImageWidth/2)^2 pooled values, in raster order of the pooled grid.
- out_map_done: 1 with the pooled value from beat (row=ImageWidth-1, col=ImageWidth-1).
- out_all_done: 1 on that same cycle when kernel=NumberOfK-1.
- When out_valid=0: out_map_done and out_all_done are 0; out_data holds its last value.
- Comparison: full-width signed. Equal values are legal and select either (identical) value.
- in_image_done on the last pixel (row=col=ImageWidth-1): consistent; normal operation.
- in_image_done on any other pixel:
  - set sync_err (stays set until reset);
  - produce no output for that beat;
  - clear col, row and pair_reg; advance kernel as if the map had completed (with wrap).
  - The next valid beat is pixel 0 of the next map.
- Last pixel arriving without in_image_done: accept silently, no error.
- Reset mid-map: the partial map is discarded; the next valid beat is pixel 0 of kernel 0.
- Back-to-back maps with no idle cycles must be supported at full rate of one pixel per clock.

Optional Feature:
- Macro: MAX_POOL_STREAM_RELU_EN.
- Defined: out_data = result if result >= 0, else 0. This fuses the activation; all other timing is unchanged.
- Undefined: out_data = result, unmodified.

Test Plan:
- Setup for all scenarios: ImageWidth=4, NumberOfK=2, BitSize=32.
- Raster map: pixels 0..15 with in_image_done on pixel 15 -> out_data 5,7,13,15; each out_valid exactly 1 clock after pixels 5,7,13,15 are accepted; out_map_done with 15; out_all_done=0; kernel_idx=0.
- Negative map: pixels -1..-16 -> outputs -1,-3,-9,-11. With MAX_POOL_STREAM_RELU_EN defined -> 0,0,0,0.
- Throttled input: same 0..15 map with random 0-3 idle cycles between beats -> identical outputs, each still 1 clock after its completing beat; no spurious out_valid.
- Two maps back-to-back with no gaps (map0 = 0..15, map1 = 100..115) -> 5,7,13,15 at idx 0, then 105,107,113,115 at idx 1; out_all_done only with 115; a third map starts at idx 0.
- Early in_image_done on pixel 9 -> sync_err=1 and stays set; only outputs 5,7 for that map; next map 0..15 yields 5,7,13,15 at kernel_idx 1.
- Reset mid-map: assert res_n=0 after 6 pixels -> all outputs 0 immediately; after release, a full map 0..15 -> 5,7,13,15 at kernel_idx 0 with sync_err=0.

Source files
------------

// File: rtl/max_pool_stream.sv
// 2x2 stride-2 signed max pooling over a raster-order feature-map stream, tagged with kernel index.
// Optional fused ReLU on the pooled output: define MAX_POOL_STREAM_RELU_EN.
module max_pool_stream #(
    parameter int BitSize    = 32,
    parameter int ImageWidth = 4,
    parameter int NumberOfK  = 4,
    localparam int KW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               in_valid,
    input  logic [BitSize-1:0] in_data,
    input  logic               in_image_done,
    output logic               out_valid,
    output logic [BitSize-1:0] out_data,
    output logic [KW-1:0]      out_kernel_idx,
    output logic               out_map_done,
    output logic               out_all_done,
    output logic               sync_err
);

    localparam int CW  = $clog2(ImageWidth);
    localparam int HW  = ImageWidth / 2;
    localparam int LBW = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ImageWidth - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(NumberOfK - 1);

    logic [CW-1:0]              col_q, col_d;
    logic [CW-1:0]              row_q, row_d;
    logic [KW-1:0]              kernel_q, kernel_d;
    logic signed [BitSize-1:0]  pair_q, pair_d;
    logic signed [BitSize-1:0]  line_buf_q [HW];
    logic signed [BitSize-1:0]  line_buf_d [HW];
    logic                       sync_err_q, sync_err_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [BitSize-1:0]  out_data_q, out_data_d;
    logic [KW-1:0]              out_kernel_idx_q, out_kernel_idx_d;
    logic                       out_map_done_q, out_map_done_d;
    logic                       out_all_done_q, out_all_done_d;

    logic                       col_last, row_last, early_done;
    logic [LBW-1:0]             lb_idx;
    logic signed [BitSize-1:0]  pixel, hmax, result, result_act;

    assign pixel      = $signed(in_data);
    assign col_last   = (col_q == COL_LAST);
    assign row_last   = (row_q == COL_LAST);
    assign early_done = in_image_done && !(col_last && row_last);
    assign lb_idx     = LBW'(col_q >> 1);
    assign hmax       = (pixel > pair_q) ? pixel : pair_q;
    assign result     = (line_buf_q[lb_idx] > hmax) ? line_buf_q[lb_idx] : hmax;

`ifdef MAX_POOL_STREAM_RELU_EN
    assign result_act = result[BitSize-1] ? '0 : result;
`else
    assign result_act = result;
`endif

    always_comb begin
        col_d            = col_q;
        row_d            = row_q;
        kernel_d         = kernel_q;
        pair_d           = pair_q;
        line_buf_d       = line_buf_q;
        sync_err_d       = sync_err_q;
        out_valid_d      = 1'b0;
        out_data_d       = out_data_q;
        out_kernel_idx_d = out_kernel_idx_q;
        out_map_done_d   = 1'b0;
        out_all_done_d   = 1'b0;

        if (in_valid) begin
            if (early_done) begin
                // Resynchronise: treat the map as finished and restart at pixel 0 of the next kernel.
                sync_err_d = 1'b1;
                col_d      = '0;
                row_d      = '0;
                pair_d     = '0;
                kernel_d   = (kernel_q == K_LAST) ? '0 : kernel_q + 1'b1;
            end else begin
                if (!col_q[0]) begin
                    pair_d = pixel;
                end else if (!row_q[0]) begin
                    line_buf_d[lb_idx] = hmax;
                end else begin
                    out_valid_d      = 1'b1;
                    out_data_d       = result_act;
                    out_kernel_idx_d = kernel_q;
                    out_map_done_d   = col_last && row_last;
                    out_all_done_d   = col_last && row_last && (kernel_q == K_LAST);
                end

                if (col_last) begin
                    col_d = '0;
                    if (row_last) begin
                        row_d    = '0;
                        kernel_d = (kernel_q == K_LAST) ? '0 : kernel_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            col_q            <= '0;
            row_q            <= '0;
            kernel_q         <= '0;
            pair_q           <= '0;
            for (int i = 0; i < HW; i++) begin
                line_buf_q[i] <= '0;
            end
            sync_err_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_kernel_idx_q <= '0;
            out_map_done_q   <= 1'b0;
            out_all_done_q   <= 1'b0;
        end else begin
            col_q            <= col_d;
            row_q            <= row_d;
            kernel_q         <= kernel_d;
            pair_q           <= pair_d;
            line_buf_q       <= line_buf_d;
            sync_err_q       <= sync_err_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_kernel_idx_q <= out_kernel_idx_d;
            out_map_done_q   <= out_map_done_d;
            out_all_done_q   <= out_all_done_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_kernel_idx = out_kernel_idx_q;
    assign out_map_done   = out_map_done_q;
    assign out_all_done   = out_all_done_q;
    assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream: ImageWidth=4, NumberOfK=2, BitSize=32, window-max reference model.
`timescale 1ns/1ps
module tb_max_pool_stream;

    localparam int BW   = 32;
    localparam int W    = 4;
    localparam int K    = 2;
    localparam int KW   = 1;
    localparam int NPIX = W * W;

    logic          clk = 1'b0;
    logic          res_n;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_image_done;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [KW-1:0] out_kernel_idx;
    logic          out_map_done;
    logic          out_all_done;
    logic          sync_err;

    always #5 clk = ~clk;

    max_pool_stream #(.BitSize(BW), .ImageWidth(W), .NumberOfK(K)) dut (
        .clk            (clk),
        .res_n          (res_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_image_done  (in_image_done),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_kernel_idx (out_kernel_idx),
        .out_map_done   (out_map_done),
        .out_all_done   (out_all_done),
        .sync_err       (sync_err)
    );

    int checks = 0;
    int errors = 0;
    int exp_kernel = 0;
    logic exp_sync = 1'b0;
    logic signed [BW-1:0] pix [NPIX];

    // Drive one cycle of input, then sample just after the clock edge that consumes it.
    task automatic step(input logic v, input logic [BW-1:0] d, input logic done);
        in_valid      = v;
        in_data       = d;
        in_image_done = done;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        res_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_image_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res_n = 1'b1;
        exp_kernel = 0;
        exp_sync = 1'b0;
    endtask

    function automatic logic signed [BW-1:0] act(input logic signed [BW-1:0] v);
`ifdef MAX_POOL_STREAM_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Maximum of the 2x2 window whose bottom-right pixel is (r, c).
    function automatic logic signed [BW-1:0] window_max(input int r, input int c);
        logic signed [BW-1:0] m;
        m = pix[(r-1)*W + c-1];
        for (int dr = -1; dr <= 0; dr++)
            for (int dc = -1; dc <= 0; dc++)
                if (pix[(r+dr)*W + c+dc] > m) m = pix[(r+dr)*W + c+dc];
        return act(m);
    endfunction

    task automatic fill_map(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0: pix[i] = i;
                1: pix[i] = -(i + 1);
                2: pix[i] = 100 + i;
                default: begin
                    pix[i] = $urandom();
                    if ($urandom_range(0, 3) == 0) pix[i] = int'($urandom_range(0, 4)) - 2;
                end
            endcase
        end
    endtask

    // Plays one map (optionally throttled / terminated early) and checks every output cycle.
    task automatic test_map(input string name, input int kind, input int max_gap, input int done_at);
        int last;
        last = (done_at >= 0 && done_at < NPIX-1) ? done_at : NPIX-1;
        fill_map(kind);
        for (int i = 0; i <= last; i++) begin
            int r, c, gaps;
            logic early, exp_v, exp_md, exp_ad;
            logic signed [BW-1:0] exp_d;
            r = i / W;
            c = i % W;
            gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, $urandom(), 1'($urandom_range(0, 1)));
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_idle before beat %0d: out_valid got %0b want 0", name, i, out_valid);
                end
            end
            step(1'b1, pix[i], i == done_at);
            early = (i == done_at) && (i != NPIX-1);
            exp_v = !early && (r % 2 == 1) && (c % 2 == 1);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL %s_valid beat %0d: out_valid got %0b want %0b", name, i, out_valid, exp_v);
            end
            exp_md = exp_v && (i == NPIX-1);
            exp_ad = exp_md && (exp_kernel == K-1);
            checks++;
            if (out_map_done !== exp_md || out_all_done !== exp_ad) begin
                errors++;
                $display("FAIL %s_flags beat %0d: map_done/all_done got %0b/%0b want %0b/%0b",
                         name, i, out_map_done, out_all_done, exp_md, exp_ad);
            end
            if (exp_v) begin
                exp_d = window_max(r, c);
                checks++;
                if (out_data !== exp_d || out_kernel_idx !== KW'(exp_kernel)) begin
                    errors++;
                    $display("FAIL %s_data beat %0d: data/idx got %0d/%0d want %0d/%0d",
                             name, i, $signed(out_data), out_kernel_idx, exp_d, exp_kernel);
                end
            end
            if (early) exp_sync = 1'b1;
        end
        exp_kernel = (exp_kernel + 1) % K;
        checks++;
        if (sync_err !== exp_sync) begin
            errors++;
            $display("FAIL %s_sync_err: got %0b want %0b", name, sync_err, exp_sync);
        end
        $display("map %s done: kernel now %0d", name, exp_kernel);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, out_data, out_kernel_idx, out_map_done, out_all_done, sync_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%0d idx=%0d md=%0b ad=%0b err=%0b want all 0",
                     out_valid, out_data, out_kernel_idx, out_map_done, out_all_done, sync_err);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        test_map("b2b_map0", 0, 0, NPIX-1);
        test_map("b2b_map1", 2, 0, NPIX-1);
        test_map("b2b_map2", 0, 0, NPIX-1);
    endtask

    task automatic test_sync_err();
        apply_reset();
        test_map("early_done", 0, 0, 9);
        test_map("after_err", 0, 0, NPIX-1);
    endtask

    task automatic test_reset_mid_map();
        fill_map(0);
        for (int i = 0; i < 6; i++) step(1'b1, pix[i], 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: out_valid got %0b want 1", out_valid);
        end
        in_valid = 1'b0;
        #2 res_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_kernel_idx, out_map_done, out_all_done, sync_err} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got valid=%0b data=%0d idx=%0d err=%0b want all 0",
                     out_valid, out_data, out_kernel_idx, sync_err);
        end
        @(posedge clk);
        #1;
        res_n = 1'b1;
        exp_kernel = 0;
        exp_sync = 1'b0;
        test_map("post_reset", 0, 0, NPIX-1);
    endtask

    task automatic test_random();
        for (int m = 0; m < 6; m++) begin
            test_map("random", 3, 2, ($urandom_range(0, 2) == 0) ? -1 : NPIX-1);
        end
    endtask

    initial begin
        res_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_image_done = 1'b0;
        test_reset();
        test_map("raster", 0, 0, NPIX-1);
        test_map("negative", 1, 0, NPIX-1);
        test_map("throttled", 0, 3, NPIX-1);
        test_back_to_back();
        test_sync_err();
        test_reset_mid_map();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
